// File: rtl/id_ex_if.sv
// id_ex_if -- signal bundle between the decode stage, the ID/EX pipeline
// register and its forwarding/hazard sources.
//   master : drives decode-side fields, flush and the M/W forwarding taps;
//            observes the E-stage results and the stall request.
//   slave  : the id_ex_stage block itself.
interface id_ex_if;
    // decode side
    logic [31:0] id_rd1, id_rd2, id_signimm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst;
    logic [2:0]  id_alucontrol;
    logic        flush_e;
    // forwarding taps from M and W
    logic        mem_regwrite;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_aluout;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_result;
    // E-stage results
    logic [31:0] srca_e, srcb_e, writedata_e;
    logic [2:0]  alucontrol_e;
    logic [4:0]  writereg_e;
    logic        regwrite_e, memtoreg_e, memwrite_e;
    logic        stall_d;

    modport master (
        output id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd,
               id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst,
               id_alucontrol, flush_e,
               mem_regwrite, mem_writereg, mem_aluout,
               wb_regwrite, wb_writereg, wb_result,
        input  srca_e, srcb_e, writedata_e, alucontrol_e, writereg_e,
               regwrite_e, memtoreg_e, memwrite_e, stall_d
    );

    modport slave (
        input  id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd,
               id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst,
               id_alucontrol, flush_e,
               mem_regwrite, mem_writereg, mem_aluout,
               wb_regwrite, wb_writereg, wb_result,
        output srca_e, srcb_e, writedata_e, alucontrol_e, writereg_e,
               regwrite_e, memtoreg_e, memwrite_e, stall_d
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding and
// hazard stall generation for a 5-stage MIPS-style pipeline.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (E registers cleared, stall_d=0)
//   bus   : id_ex_if.slave -- decode inputs, flush, M/W forwarding taps,
//           E-stage outputs and stall_d
// Build option:
//   ID_EX_FORWARD_EN defined   -> M/W forwarding muxes, stall only on load-use
//   ID_EX_FORWARD_EN undefined -> no forwarding; stall on any RAW against the
//                                 E or M destination (W is covered by the
//                                 falling-edge register-file write)
module id_ex_stage (
    input  logic    clk,
    input  logic    rst_n,
    id_ex_if.slave  bus
);

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  alucontrol;
    } e_regs_t;

    e_regs_t     e_q, e_d;
    logic [4:0]  writereg;
    logic        hazard;
    logic        stall;
    logic [31:0] srca, writedata;

    assign writereg = e_q.regdst ? e_q.rd : e_q.rt;

`ifdef ID_EX_FORWARD_EN
    // Only a load in E can't be forwarded in time; everything else resolves
    // through the M/W muxes below.
    always_comb begin
        hazard = e_q.memtoreg && e_q.regwrite && (writereg != 5'd0) &&
                 ((writereg == bus.id_rs) || (writereg == bus.id_rt));
    end

    // M has priority over W (it is the younger result); $0 never forwards.
    always_comb begin
        srca = e_q.rd1;
        if (bus.mem_regwrite && (bus.mem_writereg != 5'd0) && (bus.mem_writereg == e_q.rs))
            srca = bus.mem_aluout;
        else if (bus.wb_regwrite && (bus.wb_writereg != 5'd0) && (bus.wb_writereg == e_q.rs))
            srca = bus.wb_result;
    end

    always_comb begin
        writedata = e_q.rd2;
        if (bus.mem_regwrite && (bus.mem_writereg != 5'd0) && (bus.mem_writereg == e_q.rt))
            writedata = bus.mem_aluout;
        else if (bus.wb_regwrite && (bus.wb_writereg != 5'd0) && (bus.wb_writereg == e_q.rt))
            writedata = bus.wb_result;
    end
`else
    // Without forwarding the decoder must wait until the producer has left
    // M; W is safe because the register file writes in the first half-cycle.
    always_comb begin
        hazard = 1'b0;
        if (e_q.regwrite && (writereg != 5'd0) &&
            ((writereg == bus.id_rs) || (writereg == bus.id_rt)))
            hazard = 1'b1;
        if (bus.mem_regwrite && (bus.mem_writereg != 5'd0) &&
            ((bus.mem_writereg == bus.id_rs) || (bus.mem_writereg == bus.id_rt)))
            hazard = 1'b1;
    end

    assign srca      = e_q.rd1;
    assign writedata = e_q.rd2;

    // Forwarding taps have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_aluout, bus.wb_regwrite, bus.wb_writereg, bus.wb_result};
`endif

    // Gate with rst_n so stall_d reads 0 during reset even though the M tap
    // is an external input that may still carry stale values.
    assign stall = hazard & rst_n;

    // A stalled or flushed edge loads a bubble; flush+stall still yields a
    // single bubble because the held D instruction reloads on the next edge.
    always_comb begin
        e_d = '0;
        if (!(bus.flush_e || stall)) begin
            e_d.rd1        = bus.id_rd1;
            e_d.rd2        = bus.id_rd2;
            e_d.signimm    = bus.id_signimm;
            e_d.rs         = bus.id_rs;
            e_d.rt         = bus.id_rt;
            e_d.rd         = bus.id_rd;
            e_d.regwrite   = bus.id_regwrite;
            e_d.memtoreg   = bus.id_memtoreg;
            e_d.memwrite   = bus.id_memwrite;
            e_d.alusrc     = bus.id_alusrc;
            e_d.regdst     = bus.id_regdst;
            e_d.alucontrol = bus.id_alucontrol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= '0;
        else        e_q <= e_d;
    end

    assign bus.srca_e       = srca;
    assign bus.writedata_e  = writedata;
    assign bus.srcb_e       = e_q.alusrc ? e_q.signimm : writedata;
    assign bus.alucontrol_e = e_q.alucontrol;
    assign bus.writereg_e   = writereg;
    assign bus.regwrite_e   = e_q.regwrite;
    assign bus.memtoreg_e   = e_q.memtoreg;
    assign bus.memwrite_e   = e_q.memwrite;
    assign bus.stall_d      = stall;

endmodule
